tdm_demux: RTL and testbench
============================

# tdm_demux

Receive end of a time-division-multiplexed link: a sender multiplexes N_CH channel words onto one W-bit bus, one word per beat, with a sync flag on the slot-0 beat. This block tracks frame alignment, routes each beat to its channel register and presents a complete parallel frame with a one-cycle valid pulse. It reports alignment errors and resynchronises on its own. It sits between the serial link and per-channel consumers.

## Interface
- N_CH, 4, channels per frame; legal range 2..16.
- W, 8, bits per channel word.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat present on in_data this cycle.
- in_sync  in  1  qualifies the beat as slot 0 of a frame; ignored when in_valid=0.
- in_data  in  W  beat payload.
- out_valid  out  1  one-cycle pulse: out_data holds a new complete frame.
- out_data  out  N_CH*W  frame; slot k at out_data[k*W +: W].
- locked  out  1  alignment acquired (state LOCKED).
- sync_err  out  1  one-cycle pulse: alignment violation detected.

## Operation
- All outputs are registered. Reset values: out_valid=0, out_data=0, locked=0, sync_err=0, state=HUNT, slot counter=0, staging registers=0.
- Internal state:
  - slot counter, width $clog2(N_CH).
  - N_CH staging word registers.
  - 2-state FSM: HUNT, LOCKED.
- A beat is any cycle with in_valid=1. Cycles with in_valid=0 change nothing: counter holds and there is no timeout.
- HUNT:
  - Beat with in_sync=0: dropped; no error.
  - Beat with in_sync=1: stored to staging[0], slot=1, go to LOCKED.
- LOCKED, beat at slot s:
  - s≠0, in_sync=0: store to staging[s].
    - If s<N_CH-1, slot=s+1.
    - If s=N_CH-1, slot=0; next cycle out_data = staging with slot N_CH-1 taken from this beat, out_valid=1.
  - s=0, in_sync=1: store to staging[0], slot=1.
  - s=0, in_sync=0: sync_err=1 next cycle, beat dropped, go to HUNT, slot=0.
  - s≠0, in_sync=1: early sync. sync_err=1 next cycle. The partial frame is discarded and never emitted. The beat is stored to staging[0], slot=1, stay LOCKED.
- out_data changes only on the cycle out_valid=1 and otherwise holds the last frame.
- locked mirrors the FSM state, registered.
- Reset asserted mid-frame: the partial frame is discarded and all outputs return to reset values immediately (asynchronous).

## Timing
- Latency: out_valid and the new out_data appear on the first clk edge after the edge that accepts slot N_CH-1, i.e. 1 cycle.
- Back-to-back frames with in_valid held high produce one out_valid pulse every N_CH cycles.
- sync_err appears 1 cycle after the offending beat and is never wider than one cycle per offending beat.
- locked rises 1 cycle after the acquiring sync beat. It falls 1 cycle after a missing-sync beat at slot 0.
- out_valid and sync_err never assert in the same cycle. An early sync aborts a frame, so it cannot complete one.
- After rst deasserts, the first edge may accept a beat.

## Test plan
All scenarios use N_CH=4, W=8.
- Reset: drive rst=0 mid-stream. Required: all outputs 0 with no clock edge. Then release, send 4 beats 11,22,33,44 with sync on 11. Required: out_valid pulses once, out_data=0x44332211, locked=1.
- Hunt: after reset, send beats AA, BB without sync, then a sync frame 01,02,03,04. Required: AA/BB dropped, no sync_err, single frame 0x04030201.
- Stall: send a frame with in_valid=0 for 3 cycles between slots 1 and 2. Required: out_valid exactly 1 cycle after slot-3 beat, data intact, 0 errors.
- Continuous: send 3 back-to-back frames with in_valid always 1. Required: out_valid at cycles 4, 8, 12 after the first beat, each frame correct.
- Early sync: send slots 10,20 then sync beat 30,40,50,60. Required: sync_err pulse 1 cycle after the 30 beat, no output for the partial frame, next out_data=0x60504030, locked stays 1.
- Missing sync: after a complete frame, send 77 without sync. Required: sync_err pulse, locked=0. A subsequent sync frame 05,06,07,08 relocks and outputs 0x08070605.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive end of a TDM link: tracks frame alignment from the slot-0 sync flag,
// collects N_CH words per frame and presents each complete frame with a one-cycle pulse.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  output logic [N_CH*W-1:0] out_data,
  output logic              locked,
  output logic              sync_err
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
  localparam logic [SW-1:0] SLOT_ZERO = SW'(0);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_r;
  logic [SW-1:0]       slot_r;
  logic [W-1:0]        staging_r [N_CH];
  logic [N_CH*W-1:0]   frame_s;

  // Complete frame as it would look if the current beat fills the last slot
  always_comb begin
    frame_s = {(N_CH*W){1'b0}};
    for (int k = 0; k < N_CH - 1; k++) begin
      frame_s[k*W +: W] = staging_r[k];
    end
    frame_s[(N_CH-1)*W +: W] = in_data;
  end

  // Alignment FSM, slot routing and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= HUNT;
      slot_r    <= SLOT_ZERO;
      out_valid <= 1'b0;
      out_data  <= {(N_CH*W){1'b0}};
      locked    <= 1'b0;
      sync_err  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        staging_r[k] <= {W{1'b0}};
      end
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            if (in_sync) begin
              staging_r[0] <= in_data;
              slot_r       <= SLOT_ONE;
              state_r      <= LOCKED;
              locked       <= 1'b1;
            end else begin
              slot_r <= SLOT_ZERO;
            end
          end
          LOCKED: begin
            if (slot_r == SLOT_ZERO) begin
              if (in_sync) begin
                staging_r[0] <= in_data;
                slot_r       <= SLOT_ONE;
              end else begin
                sync_err <= 1'b1;
                slot_r   <= SLOT_ZERO;
                state_r  <= HUNT;
                locked   <= 1'b0;
              end
            end else if (in_sync) begin
              // Early sync: abandon the partial frame and restart at slot 0
              sync_err     <= 1'b1;
              staging_r[0] <= in_data;
              slot_r       <= SLOT_ONE;
            end else begin
              staging_r[slot_r] <= in_data;
              if (slot_r == LAST_SLOT) begin
                slot_r    <= SLOT_ZERO;
                out_valid <= 1'b1;
                out_data  <= frame_s;
              end else begin
                slot_r <= slot_r + SLOT_ONE;
              end
            end
          end
          default: begin
            state_r <= HUNT;
            slot_r  <= SLOT_ZERO;
            locked  <= 1'b0;
          end
        endcase
      end else begin
        slot_r <= slot_r;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Randomised and directed scoreboard bench for tdm_demux with a queue-based
// frame model; a separate monitor pops expected events as the DUT emits them.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_sync;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic [N_CH*W-1:0] out_data;
  logic              locked;
  logic              sync_err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .locked(locked), .sync_err(sync_err)
  );

  typedef struct {
    bit                is_err;
    logic [N_CH*W-1:0] data;
    int                cyc;
  } ev_t;

  ev_t          exp_q[$];
  logic [W-1:0] part[$];
  bit           m_locked;
  logic [N_CH*W-1:0] last_frame;
  int           cyc;
  int           tests;
  int           fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is a sync word followed by N_CH-1 non-sync words.
  task automatic model_beat(input bit s, input logic [W-1:0] d, input int ecyc);
    ev_t e;
    logic [N_CH*W-1:0] f;
    e.is_err = 1'b1; e.data = '0; e.cyc = ecyc;
    if (!m_locked) begin
      if (s) begin part.delete(); part.push_back(d); m_locked = 1'b1; end
    end else if (s) begin
      if (part.size() != 0) exp_q.push_back(e);
      part.delete(); part.push_back(d);
    end else if (part.size() == 0) begin
      exp_q.push_back(e);
      m_locked = 1'b0;
    end else begin
      part.push_back(d);
      if (part.size() == N_CH) begin
        f = '0;
        for (int k = 0; k < N_CH; k++) f[k*W +: W] = part[k];
        e.is_err = 1'b0; e.data = f;
        exp_q.push_back(e);
        part.delete();
      end
    end
  endtask

  task automatic beat(input bit v, input bit s, input logic [W-1:0] d);
    @(negedge clk);
    chk("locked", {63'd0, locked}, {63'd0, m_locked});
    in_valid = v; in_sync = s; in_data = d;
    if (v) model_beat(s, d, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    beat(1'b1, 1'b1, a); beat(1'b1, 1'b0, b); beat(1'b1, 1'b0, c); beat(1'b1, 1'b0, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; in_sync = 1'b0; in_data = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_sync_err", {63'd0, sync_err}, 64'd0);
    exp_q.delete(); part.delete(); m_locked = 1'b0; last_frame = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    ev_t e;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        if (out_valid && sync_err) chk("valid_err_overlap", 64'd1, 64'd0);
        if (out_valid || sync_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {62'd0, out_valid, sync_err}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", {63'd0, sync_err}, {63'd0, e.is_err});
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            if (!e.is_err) last_frame = e.data;
          end
        end
        chk("out_data_hold", {32'd0, out_data}, {32'd0, last_frame});
      end
    end
  end

  initial begin
    int gpos;
    bit v, s;
    cyc = 0; tests = 0; fails = 0;
    rst = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = 8'h00;
    m_locked = 1'b0; last_frame = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset mid-stream, then a clean frame
    beat(1'b1, 1'b1, 8'h99); beat(1'b1, 1'b0, 8'h98);
    do_reset();
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    idle(2);
    chk("rst_frame", {32'd0, out_data}, 64'h44332211);
    chk("rst_frame_locked", {63'd0, locked}, 64'd1);

    // Hunt: unsynced beats dropped
    do_reset();
    beat(1'b1, 1'b0, 8'hAA); beat(1'b1, 1'b0, 8'hBB);
    frame(8'h01, 8'h02, 8'h03, 8'h04);
    idle(2);
    chk("hunt_frame", {32'd0, out_data}, 64'h04030201);

    // Stall between slots 1 and 2
    beat(1'b1, 1'b1, 8'hC0); beat(1'b1, 1'b0, 8'hC1);
    idle(3);
    beat(1'b1, 1'b0, 8'hC2); beat(1'b1, 1'b0, 8'hC3);
    idle(2);

    // Continuous back-to-back frames
    frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    frame(8'hD0, 8'hD1, 8'hD2, 8'hD3);
    idle(2);

    // Early sync
    beat(1'b1, 1'b1, 8'h10); beat(1'b1, 1'b0, 8'h20);
    frame(8'h30, 8'h40, 8'h50, 8'h60);
    idle(2);
    chk("early_frame", {32'd0, out_data}, 64'h60504030);

    // Missing sync then relock
    beat(1'b1, 1'b0, 8'h77);
    idle(1);
    chk("missing_unlocked", {63'd0, locked}, 64'd0);
    frame(8'h05, 8'h06, 8'h07, 8'h08);
    idle(2);
    chk("relock_frame", {32'd0, out_data}, 64'h08070605);

    // Random traffic with occasional alignment faults
    gpos = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 8);
      s = (gpos == 0);
      if ($urandom_range(0, 19) == 0) s = ~s;
      beat(v, s, 8'($urandom));
      if (v) gpos = (s ? 1 : gpos + 1) % N_CH;
    end
    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
